// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard front end: prefix byte values,
// the frame receiver state type and the packed key event record held in
// the event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_frame_state_t;

  // 'repeat' is a reserved word, so the repeat tag is called is_repeat
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic       is_repeat;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// Synchronises the raw PS/2 lines, detects falling edges of ps2_clk and
// shifts in 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 lines
//   rx_byte, rx_stb     received byte and its 1-cycle strobe
//   err_parity          1-cycle pulse, frame dropped for bad parity
//   err_frame           1-cycle pulse, bad start/stop or mid-frame timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_stb,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   data_bit;

  ps2_frame_state_t state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             par_bit;
  logic [TO_W-1:0]  to_cnt;

  // Synchronisers reset to the idle-high bus level so reset never fakes a fall
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_bit = data_sync[SYNC_STAGES-1];

  // Frame FSM; the timeout check comes last so it overrides any state move
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      rx_stb     <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      rx_stb     <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;

      if (state == ST_IDLE || fall) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (fall && !data_bit) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (fall) begin
            shift   <= {data_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (fall) begin
            par_bit <= data_bit;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall) begin
            state <= ST_IDLE;
            if (!data_bit)                    err_frame  <= 1'b1;
            else if (!(^{shift, par_bit}))    err_parity <= 1'b1;
            else begin
              rx_byte <= shift;
              rx_stb  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (state != ST_IDLE && !fall && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        state     <= ST_IDLE;
        err_frame <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_event_rx.sv
// ps2_kbd_event_rx
// PS/2 keyboard front end: frame reception, E0/F0 prefix folding, held-key
// and typematic repeat tracking, new-press counter and a valid/ready event FIFO.
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   ps2_clk, ps2_data             raw PS/2 lines
//   ev_valid/ev_ready             FIFO head handshake
//   ev_code/ev_ext/ev_brk/ev_repeat  head event fields (0 when empty)
//   fifo_level                    stored entries
//   is_press, held_code           currently held key
//   count                         new presses since reset
//   err_parity, err_frame         1-cycle error pulses
//   overflow                      sticky, event dropped on full FIFO
module ps2_kbd_event_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_W     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter bit REPEAT_EN   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic                          ev_repeat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          is_press,
  output logic [7:0]                    held_code,
  output logic [COUNT_W-1:0]            count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  logic [7:0] rx_byte;
  logic       rx_stb;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .rx_stb     (rx_stb),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  logic       pfx_ext;
  logic       pfx_brk;
  logic       push_valid;
  ps2_event_t push_ev;

  // Decoder: the byte strobe arrives at E+1, the registered push lands at E+2
  always_ff @(posedge clk) begin
    if (rst) begin
      pfx_ext    <= 1'b0;
      pfx_brk    <= 1'b0;
      push_valid <= 1'b0;
      push_ev    <= '0;
      is_press   <= 1'b0;
      held_code  <= '0;
      count      <= '0;
    end else begin
      push_valid <= 1'b0;
      if (rx_stb) begin
        if (rx_byte == PS2_PFX_EXT) begin
          pfx_ext <= 1'b1;
        end else if (rx_byte == PS2_PFX_BRK) begin
          pfx_brk <= 1'b1;
        end else begin
          pfx_ext <= 1'b0;
          pfx_brk <= 1'b0;
          if (pfx_brk) begin
            if (rx_byte == held_code) begin
              is_press  <= 1'b0;
              held_code <= '0;
            end
            push_valid <= 1'b1;
            push_ev    <= '{ext: pfx_ext, brk: 1'b1, is_repeat: 1'b0, code: rx_byte};
          end else if (is_press && rx_byte == held_code) begin
            push_valid <= REPEAT_EN;
            push_ev    <= '{ext: pfx_ext, brk: 1'b0, is_repeat: 1'b1, code: rx_byte};
          end else begin
            count      <= count + 1'b1;
            is_press   <= 1'b1;
            held_code  <= rx_byte;
            push_valid <= 1'b1;
            push_ev    <= '{ext: pfx_ext, brk: 1'b0, is_repeat: 1'b0, code: rx_byte};
          end
        end
      end
    end
  end

  ps2_event_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;

  assign fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign do_pop    = ev_valid & ev_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push   = push_valid & (~fifo_full | do_pop);

  // Circular buffer; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      fifo_level <= fifo_level + 1'b1;
      else if (!do_push && do_pop) fifo_level <= fifo_level - 1'b1;
      if (push_valid && !do_push) overflow <= 1'b1;
    end
  end

  assign ev_valid  = (fifo_level != '0);
  assign ev_code   = ev_valid ? mem[rd_ptr].code      : 8'h00;
  assign ev_ext    = ev_valid ? mem[rd_ptr].ext       : 1'b0;
  assign ev_brk    = ev_valid ? mem[rd_ptr].brk       : 1'b0;
  assign ev_repeat = ev_valid ? mem[rd_ptr].is_repeat : 1'b0;

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// tb_ps2_kbd_event_rx
// Directed bench: a table of byte sequences with expected head event and
// hold/count state, followed by hand-written error, timeout and overflow
// sequences. A second instance with REPEAT_EN=0 shares the PS/2 lines.
module tb_ps2_kbd_event_rx;

  localparam int DEPTH   = 8;
  localparam int TMO     = 300;
  localparam int HALF    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;

  logic       ev_valid, ev_ext, ev_brk, ev_repeat;
  logic [7:0] ev_code, held_code, count;
  logic [3:0] fifo_level;
  logic       is_press, err_parity, err_frame, overflow;

  logic       nr_valid, nr_ext, nr_brk, nr_repeat;
  logic [7:0] nr_code, nr_held, nr_count;
  logic [3:0] nr_level;
  logic       nr_press, nr_perr, nr_ferr, nr_ovf;

  int tests = 0;
  int fails = 0;
  int par_errs = 0;
  int frm_errs = 0;
  int nr_pops = 0;

  always #5 clk = ~clk;

  ps2_kbd_event_rx #(
    .FIFO_DEPTH(DEPTH), .COUNT_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_brk(ev_brk), .ev_repeat(ev_repeat), .fifo_level(fifo_level),
    .is_press(is_press), .held_code(held_code), .count(count),
    .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow)
  );

  ps2_kbd_event_rx #(
    .FIFO_DEPTH(DEPTH), .COUNT_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(nr_valid), .ev_ready(ev_ready), .ev_code(nr_code), .ev_ext(nr_ext),
    .ev_brk(nr_brk), .ev_repeat(nr_repeat), .fifo_level(nr_level),
    .is_press(nr_press), .held_code(nr_held), .count(nr_count),
    .err_parity(nr_perr), .err_frame(nr_ferr), .overflow(nr_ovf)
  );

  // Error pulses and the no-repeat instance's handshakes are tallied here
  always @(posedge clk) begin
    if (!rst && err_parity) par_errs++;
    if (!rst && err_frame)  frm_errs++;
    if (!rst && nr_valid && ev_ready) nr_pops++;
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nb;
    logic       e_ext, e_brk, e_rpt;
    logic [7:0] e_code;
    logic       e_press;
    logic [7:0] e_held;
    logic [7:0] e_count;
    int         e_nr;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int nbits);
    logic [10:0] frame;
    frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    send_frame(v.b0, 1'b0, 1'b0, 11);
    if (v.nb > 1) send_frame(v.b1, 1'b0, 1'b0, 11);
    if (v.nb > 2) send_frame(v.b2, 1'b0, 1'b0, 11);
    repeat (20) @(posedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) ev_ready = 1'b1;
    @(negedge clk) ev_ready = 1'b0;
  endtask

  initial begin
    int nr_snap;
    int perr_snap;
    int ferr_snap;

    vecs[0] = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, 8'h1C, 8'd1, 1};
    vecs[1] = '{8'hF0, 8'h1C, 8'h00, 2, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 8'h00, 8'd1, 1};
    vecs[2] = '{8'hE0, 8'h75, 8'h00, 2, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 8'h75, 8'd2, 1};
    vecs[3] = '{8'hE0, 8'hF0, 8'h75, 3, 1'b1, 1'b1, 1'b0, 8'h75, 1'b0, 8'h00, 8'd2, 1};
    vecs[4] = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, 8'h1C, 8'd3, 1};
    vecs[5] = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, 8'h1C, 8'd3, 0};
    vecs[6] = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, 8'h1C, 8'd3, 0};
    vecs[7] = '{8'h32, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h32, 1'b1, 8'h32, 8'd4, 1};
    vecs[8] = '{8'hF0, 8'h1C, 8'h00, 2, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 8'h32, 8'd4, 1};
    vecs[9] = '{8'hF0, 8'h32, 8'h00, 2, 1'b0, 1'b1, 1'b0, 8'h32, 1'b0, 8'h00, 8'd4, 1};

    repeat (5) @(posedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset ev_valid", ev_valid, 0);
    checkOutput("reset fifo_level", fifo_level, 0);
    checkOutput("reset count", count, 0);
    checkOutput("reset is_press", is_press, 0);
    checkOutput("reset held_code", held_code, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset ev_code", ev_code, 0);

    for (int i = 0; i < 10; i++) begin
      nr_snap = nr_pops;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d ev_valid", i), ev_valid, 1);
      checkOutput($sformatf("v%0d fifo_level", i), fifo_level, 1);
      checkOutput($sformatf("v%0d ev_code", i), ev_code, vecs[i].e_code);
      checkOutput($sformatf("v%0d ev_ext", i), ev_ext, vecs[i].e_ext);
      checkOutput($sformatf("v%0d ev_brk", i), ev_brk, vecs[i].e_brk);
      checkOutput($sformatf("v%0d ev_repeat", i), ev_repeat, vecs[i].e_rpt);
      checkOutput($sformatf("v%0d is_press", i), is_press, vecs[i].e_press);
      checkOutput($sformatf("v%0d held_code", i), held_code, vecs[i].e_held);
      checkOutput($sformatf("v%0d count", i), count, vecs[i].e_count);
      pop_one();
      @(negedge clk);
      checkOutput($sformatf("v%0d level after pop", i), fifo_level, 0);
      checkOutput($sformatf("v%0d no-repeat events", i), nr_pops - nr_snap, vecs[i].e_nr);
    end

    // Flipped parity bit: error pulse, nothing pushed
    perr_snap = par_errs;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    repeat (20) @(negedge clk);
    checkOutput("parity err pulse", par_errs - perr_snap, 1);
    checkOutput("parity no event", fifo_level, 0);

    // Stop bit low: frame error, nothing pushed
    ferr_snap = frm_errs;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    repeat (20) @(negedge clk);
    checkOutput("stop err pulse", frm_errs - ferr_snap, 1);
    checkOutput("stop no event", fifo_level, 0);

    // Stall after four bits, then a good frame must still decode
    ferr_snap = frm_errs;
    send_frame(8'hAA, 1'b0, 1'b0, 4);
    repeat (TMO + 50) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout err pulse", frm_errs - ferr_snap, 1);
    send_frame(8'h2A, 1'b0, 1'b0, 11);
    repeat (20) @(negedge clk);
    checkOutput("post-timeout ev_code", ev_code, 8'h2A);
    checkOutput("post-timeout count", count, 5);
    pop_one();

    // Overflow: DEPTH+1 distinct makes with the consumer stalled
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 11);
    repeat (20) @(negedge clk);
    checkOutput("full level", fifo_level, DEPTH);
    checkOutput("overflow sticky", overflow, 1);
    checkOutput("overflow count", count, 14);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checkOutput($sformatf("drain %0d code", i), ev_code, 8'h10 + 8'(i));
      pop_one();
    end
    @(negedge clk);
    checkOutput("drained level", fifo_level, 0);
    checkOutput("drained ev_valid", ev_valid, 0);
    checkOutput("overflow still set", overflow, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
